activation_unit: RTL and testbench
==================================

Name: activation_unit

Overview:
- Streaming, parametrised activation stage for the NAR-Net datapath. It sits between the MAC accumulator output and the next layer's input buffer.
- Supports four run-time modes: tanh, sigmoid, ReLU and bypass. Tanh uses an odd-symmetric half-table with linear interpolation; sigmoid is derived from the same table.
- Fully pipelined with valid/ready back-pressure and a pass-through tag for neuron/channel indexing.

Parameters:
- DATA_W, 8: input/output width, two's complement, Q(DATA_W-FRAC_W).FRAC_W.
- FRAC_W, 5: fractional bits. Constraint: DATA_W-FRAC_W >= 2, so that +1.0 is representable.
- LUT_AW, 6: table index bits. Constraint: LUT_AW <= DATA_W-1. SEG_BITS = DATA_W-1-LUT_AW is the interpolation fraction width.
- TAG_W, 4: sideband tag width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  unit can accept a beat.
- in_data  in  DATA_W  signed pre-activation value.
- in_mode  in  2  activation select: 0 tanh, 1 sigmoid, 2 ReLU, 3 bypass. Sampled with the beat.
- in_tag  in  TAG_W  sideband tag, carried unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  DATA_W  signed activated value.
- out_tag  out  TAG_W  tag of the beat in out_data.

Behaviour:
- Reset:
  - All stage valids, out_valid, out_data and out_tag go to 0; in_ready is 1 after reset.
  - Asserting rst mid-operation drops every in-flight beat. No partial output is produced.
- Pipeline: three register stages, all on rising clk. Latency is exactly 3 cycles from an accepted input to out_valid when there is no stall.
- Stall rule:
  - advance = !out_valid || out_ready.
  - All stages hold when advance is 0.
  - in_ready = advance.
  - A beat transfers when valid && ready on the same edge.
  - A bubble in any stage is overwritten on advance. Throughput is 1 beat/cycle when out_ready is held high.
- S1 (decode):
  - Sign s = in_data MSB.
  - Tanh argument: a = in_data in tanh mode; a = in_data >>> 1 (arithmetic) in sigmoid mode.
  - Magnitude m = |a|, saturated to 2^(DATA_W-1)-1 for the most negative code.
  - i = m >> SEG_BITS; f = m[SEG_BITS-1:0].
  - Mode, sign, raw in_data and tag are carried forward.
- S2 (table):
  - Registered read of T[i] and T[i+1].
  - Table has 2^LUT_AW+1 entries: T[k] = round(tanh(k·2^SEG_BITS / 2^FRAC_W)·2^FRAC_W), unsigned, maximum 2^FRAC_W.
  - The table is monotonic non-decreasing.
- S3 (interpolate/post):
  - y = T[i] + (((T[i+1]-T[i])·f) >> SEG_BITS), truncating. When SEG_BITS = 0, y = T[i].
  - tanh: out = s ? -y : y. Exact odd symmetry holds: f(-x) = -f(x), and f(0) = 0.
  - sigmoid: t = signed tanh result; out = (2^FRAC_W + t) >> 1. Range is 0..2^FRAC_W.
  - ReLU: out = s ? 0 : in_data.
  - bypass: out = in_data.
- No arithmetic wraps: all intermediates are sized DATA_W+SEG_BITS+1, and outputs always fit in DATA_W.
- Mode switching:
  - A mode change between consecutive beats needs no flush.
  - Each beat is processed in its own mode.
- Simultaneous output handshake and new input: when out_valid && out_ready && in_valid, the pipeline advances and accepts the new beat on the same edge.

Decomposition:
- Shared package act_pkg holds:
  - mode encodings ACT_TANH = 2'd0, ACT_SIGMOID = 2'd1, ACT_RELU = 2'd2, ACT_BYPASS = 2'd3;
  - the table-generation function (real-valued tanh, rounded), so the ROM contents follow DATA_W, FRAC_W and LUT_AW.
- One sub-module, act_tanh_rom:
  - dual-read registered ROM of the positive half-table, with an enable input tied to advance;
  - generated from act_pkg at elaboration.

Test Plan (defaults DATA_W=8, FRAC_W=5, LUT_AW=6; out_ready=1 unless stated):
- Tanh, single beats, each with out_valid exactly 3 cycles after acceptance:
  - 0x20 (1.0) -> 0x18 (24).
  - 0xE0 (-1.0) -> 0xE8 (-24).
  - 0x00 -> 0x00.
  - 0x21 -> 0x18 (interpolated: T16=24, T17=25, f=1).
- Tanh saturation:
  - 0x7F -> 0x20.
  - 0x80 -> 0xE0 (magnitude saturated, no wrap).
  - 0xFF -> 0xFF (0 after truncation is not allowed; -1/32 maps to -T0-interp; T0=0, T1=2, f=1 -> y=1 -> 0xFF).
- Sigmoid:
  - 0x00 -> 0x10.
  - 0x40 (2.0) -> 0x1C (28).
  - 0xC0 -> 0x04.
  - 0x80 -> 0x00 or above, never negative.
- ReLU and bypass: ReLU 0xFB -> 0x00; ReLU 0x28 -> 0x28; bypass 0x9C -> 0x9C.
- Back-pressure:
  - Stream 8 beats with alternating modes and tags 0..7, holding out_ready low for 5 cycles mid-stream.
  - Required: in_ready drops; no beat is lost or duplicated; output order and tags are 0..7; each result matches its own mode.
- Reset mid-stream:
  - Assert rst while 3 beats are in flight.
  - Required: out_valid = 0 immediately (asynchronous), out_data = 0, out_tag = 0; no stale beat appears after release.
  - The first beat after release appears 3 cycles after acceptance.

Source files
------------

// File: rtl/act_pkg.sv
// Shared definitions for the activation unit.
//   act_mode_e      : run-time activation select carried with each beat.
//   act_exp         : real-valued exponential, used only while building the table.
//   act_tanh_entry  : one entry of the positive tanh half-table,
//                     round(tanh(k * 2^seg_bits / 2^frac_w) * 2^frac_w).
package act_pkg;

    typedef enum logic [1:0] {
        ACT_TANH    = 2'd0,
        ACT_SIGMOID = 2'd1,
        ACT_RELU    = 2'd2,
        ACT_BYPASS  = 2'd3
    } act_mode_e;

    // Argument is halved until small so a short Taylor series converges,
    // then the result is squared back up.
    function automatic real act_exp(input real y);
        real x;
        real r;
        real term;
        int  n;
        x = y;
        n = 0;
        while (x > 0.5) begin
            x = x / 2.0;
            n = n + 1;
        end
        r    = 1.0;
        term = 1.0;
        for (int j = 1; j <= 24; j++) begin
            term = term * x / $itor(j);
            r    = r + term;
        end
        for (int j = 0; j < n; j++) begin
            r = r * r;
        end
        return r;
    endfunction

    function automatic int act_tanh_entry(input int k, input int seg_bits, input int frac_w);
        real scale;
        real x;
        real e2;
        real th;
        scale = $itor(1 << frac_w);
        x     = $itor(k * (1 << seg_bits)) / scale;
        e2    = act_exp(2.0 * x);
        th    = (e2 - 1.0) / (e2 + 1.0);
        return $rtoi(th * scale + 0.5);
    endfunction

endpackage

// File: rtl/act_tanh_rom.sv
// Dual-read registered ROM holding the positive half of the tanh table.
// Contents are generated from act_pkg, so they track FRAC_W, LUT_AW and SEG_BITS.
// Ports:
//   clk  : rising-edge clock
//   en   : read enable; both outputs hold when low
//   addr : table index i
//   lo   : T[i]   (registered)
//   hi   : T[i+1] (registered)
module act_tanh_rom #(
    parameter int LUT_AW   = 6,
    parameter int FRAC_W   = 5,
    parameter int SEG_BITS = 1
) (
    input  logic              clk,
    input  logic              en,
    input  logic [LUT_AW-1:0] addr,
    output logic [FRAC_W:0]   lo,
    output logic [FRAC_W:0]   hi
);
    import act_pkg::*;

    localparam int DEPTH = (1 << LUT_AW) + 1;

    logic [FRAC_W:0] table_mem [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_entry
        assign table_mem[k] = (FRAC_W+1)'(act_tanh_entry(k, SEG_BITS, FRAC_W));
    end

    // One extra address bit so that i+1 reaches the closing entry T[2^LUT_AW].
    logic [LUT_AW:0] addr_lo;
    logic [LUT_AW:0] addr_hi;

    assign addr_lo = {1'b0, addr};
    assign addr_hi = addr_lo + (LUT_AW+1)'(1);

    always_ff @(posedge clk) begin
        if (en) begin
            lo <= table_mem[addr_lo];
            hi <= table_mem[addr_hi];
        end
    end

endmodule

// File: rtl/activation_unit.sv
// Streaming activation stage: tanh, sigmoid, ReLU or bypass per beat.
// Three register stages (decode, table read, interpolate/post) with a single
// global advance used as the stall enable for every stage.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : input handshake
//   in_data             : signed pre-activation value, Q(DATA_W-FRAC_W).FRAC_W
//   in_mode             : 0 tanh, 1 sigmoid, 2 ReLU, 3 bypass
//   in_tag              : sideband tag, carried unchanged
//   out_valid/out_ready : output handshake
//   out_data            : signed activated value
//   out_tag             : tag of the beat in out_data
module activation_unit #(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 5,
    parameter int LUT_AW = 6,
    parameter int TAG_W  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic [1:0]               in_mode,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]         out_tag
);
    import act_pkg::*;

    localparam int SEG_BITS = DATA_W - 1 - LUT_AW;
    localparam int FW       = (SEG_BITS > 0) ? SEG_BITS : 1;
    localparam int IW       = DATA_W + SEG_BITS + 1;
    localparam int MW       = DATA_W - 1;

    localparam logic signed [DATA_W-1:0] MIN_VAL   = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [MW-1:0]            MAG_MAX   = '1;
    localparam logic [MW-1:0]            FRAC_MASK = MW'((1 << SEG_BITS) - 1);
    localparam logic signed [IW-1:0]     ONE       = IW'(1 << FRAC_W);

    // |a|, with the most negative code clamped instead of wrapping.
    function automatic logic [MW-1:0] sat_mag(input logic signed [DATA_W-1:0] a);
        logic signed [DATA_W-1:0] n;
        if (a == MIN_VAL) begin
            return MAG_MAX;
        end
        n = (a < 0) ? -a : a;
        return MW'(n);
    endfunction

    // Truncating linear interpolation between adjacent table entries.
    function automatic logic signed [IW-1:0] interp(input logic [FRAC_W:0] lo,
                                                    input logic [FRAC_W:0] hi,
                                                    input logic [FW-1:0]   frac);
        logic signed [IW-1:0] lo_s;
        logic signed [IW-1:0] hi_s;
        logic signed [IW-1:0] frac_s;
        logic signed [IW-1:0] step;
        lo_s   = IW'(lo);
        hi_s   = IW'(hi);
        frac_s = IW'(frac);
        step   = ((hi_s - lo_s) * frac_s) >>> SEG_BITS;
        return lo_s + step;
    endfunction

    // sigmoid(x) = (1 + tanh(x/2)) / 2, the halving of x was done at decode.
    function automatic logic signed [IW-1:0] sigmoid_post(input logic signed [IW-1:0] t);
        return (ONE + t) >>> 1;
    endfunction

    logic advance;

    logic                     vld_p0, vld_p1, vld_p2;
    act_mode_e                mode_p0, mode_p1;
    logic                     sgn_p0, sgn_p1;
    logic signed [DATA_W-1:0] raw_p0, raw_p1;
    logic [TAG_W-1:0]         tag_p0, tag_p1, tag_p2;
    logic [LUT_AW-1:0]        idx_p0;
    logic [FW-1:0]            frac_p0, frac_p1;
    logic [FRAC_W:0]          lo_p1, hi_p1;
    logic signed [DATA_W-1:0] data_p2;

    logic signed [DATA_W-1:0] arg_d;
    logic [MW-1:0]            mag_d;
    logic [LUT_AW-1:0]        idx_d;
    logic [FW-1:0]            frac_d;
    logic signed [IW-1:0]     y_d;
    logic signed [IW-1:0]     t_d;
    logic signed [DATA_W-1:0] res_d;

    assign advance   = !vld_p2 || out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_p2;
    assign out_data  = data_p2;
    assign out_tag   = tag_p2;

    // ---- stage 0: decode ----
    always_comb begin
        arg_d  = (in_mode == ACT_SIGMOID) ? (in_data >>> 1) : in_data;
        mag_d  = sat_mag(arg_d);
        idx_d  = LUT_AW'(mag_d >> SEG_BITS);
        frac_d = FW'(mag_d & FRAC_MASK);
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            mode_p0 <= act_mode_e'(in_mode);
            sgn_p0  <= in_data[DATA_W-1];
            raw_p0  <= in_data;
            tag_p0  <= in_tag;
            idx_p0  <= idx_d;
            frac_p0 <= frac_d;
        end
    end

    // ---- stage 1: table read ----
    act_tanh_rom #(
        .LUT_AW   (LUT_AW),
        .FRAC_W   (FRAC_W),
        .SEG_BITS (SEG_BITS)
    ) u_rom (
        .clk  (clk),
        .en   (advance),
        .addr (idx_p0),
        .lo   (lo_p1),
        .hi   (hi_p1)
    );

    always_ff @(posedge clk) begin
        if (advance) begin
            mode_p1 <= mode_p0;
            sgn_p1  <= sgn_p0;
            raw_p1  <= raw_p0;
            tag_p1  <= tag_p0;
            frac_p1 <= frac_p0;
        end
    end

    // ---- stage 2: interpolate and post-process ----
    always_comb begin
        y_d   = interp(lo_p1, hi_p1, frac_p1);
        t_d   = sgn_p1 ? -y_d : y_d;
        res_d = raw_p1;
        case (mode_p1)
            ACT_TANH:    res_d = DATA_W'(t_d);
            ACT_SIGMOID: res_d = DATA_W'(sigmoid_post(t_d));
            ACT_RELU:    res_d = sgn_p1 ? '0 : raw_p1;
            default:     res_d = raw_p1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            data_p2 <= '0;
            tag_p2  <= '0;
        end else if (advance) begin
            vld_p0  <= in_valid;
            vld_p1  <= vld_p0;
            vld_p2  <= vld_p1;
            data_p2 <= res_d;
            tag_p2  <= tag_p1;
        end
    end

endmodule

// File: tb/tb_activation_unit.sv
module tb_activation_unit;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] in_data;
    logic [1:0]        in_mode;
    logic [3:0]        in_tag;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] out_data;
    logic [3:0]        out_tag;

    int vectors;
    int miscompares;

    activation_unit #(
        .DATA_W (8),
        .FRAC_W (5),
        .LUT_AW (6),
        .TAG_W  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one beat, waits for its result; lat counts edges from the
    // accepting edge (inclusive) to the edge that raised out_valid.
    task automatic run_beat(input logic [1:0] mode, input logic [7:0] data,
                            input logic [3:0] tag, output logic [7:0] got,
                            output logic [3:0] got_tag, output int lat);
        @(negedge clk);
        in_valid = 1'b1;
        in_mode  = mode;
        in_data  = data;
        in_tag   = tag;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
        in_tag   = '0;
        lat = 1;
        while (!out_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        got     = out_data;
        got_tag = out_tag;
    endtask

    task automatic check_beats(input string name, input logic [1:0] modes[4],
                               input logic [7:0] din[4], input logic [7:0] exp_q[4]);
        logic [7:0] got;
        logic [3:0] gt;
        int         lat;
        for (int k = 0; k < 4; k++) begin
            run_beat(modes[k], din[k], 4'(k + 3), got, gt, lat);
            vectors++;
            if (got !== exp_q[k]) begin
                miscompares++;
                $display("FAIL %s[%0d] in=%h data got %h expected %h", name, k, din[k], got, exp_q[k]);
            end
            vectors++;
            if (lat !== 3) begin
                miscompares++;
                $display("FAIL %s[%0d] latency got %0d expected 3", name, k, lat);
            end
            vectors++;
            if (gt !== 4'(k + 3)) begin
                miscompares++;
                $display("FAIL %s[%0d] tag got %h expected %h", name, k, gt, 4'(k + 3));
            end
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_tag !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_outputs got v=%b d=%h t=%h expected v=0 d=00 t=0", out_valid, out_data, out_tag);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_tanh();
        logic [1:0] m[4] = '{2'd0, 2'd0, 2'd0, 2'd0};
        logic [7:0] d[4] = '{8'h20, 8'hE0, 8'h00, 8'h21};
        logic [7:0] e[4] = '{8'h18, 8'hE8, 8'h00, 8'h18};
        check_beats("tanh", m, d, e);
    endtask

    task automatic test_tanh_sat();
        logic [1:0] m[4] = '{2'd0, 2'd0, 2'd0, 2'd0};
        logic [7:0] d[4] = '{8'h7F, 8'h80, 8'hFF, 8'h01};
        logic [7:0] e[4] = '{8'h20, 8'hE0, 8'hFF, 8'h01};
        check_beats("tanh_sat", m, d, e);
    endtask

    task automatic test_sigmoid();
        logic [1:0] m[4] = '{2'd1, 2'd1, 2'd1, 2'd1};
        logic [7:0] d[4] = '{8'h00, 8'h40, 8'hC0, 8'h80};
        logic [7:0] e[4] = '{8'h10, 8'h1C, 8'h04, 8'h00};
        check_beats("sigmoid", m, d, e);
    endtask

    task automatic test_relu_bypass();
        logic [1:0] m[4] = '{2'd2, 2'd2, 2'd3, 2'd3};
        logic [7:0] d[4] = '{8'hFB, 8'h28, 8'h9C, 8'h80};
        logic [7:0] e[4] = '{8'h00, 8'h28, 8'h9C, 8'h80};
        check_beats("relu_bypass", m, d, e);
    endtask

    task automatic test_back_pressure();
        logic [1:0] m[8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        logic [7:0] d[8] = '{8'h20, 8'h00, 8'h28, 8'h9C, 8'hE0, 8'h40, 8'hFB, 8'h11};
        logic [7:0] e[8] = '{8'h18, 8'h10, 8'h28, 8'h9C, 8'hE8, 8'h1C, 8'h00, 8'h11};
        int  sent;
        int  rcvd;
        int  cyc;
        bit  saw_stall;
        bit  in_acc;
        bit  out_acc;
        sent      = 0;
        rcvd      = 0;
        cyc       = 0;
        saw_stall = 1'b0;
        while (rcvd < 8 && cyc < 60) begin
            @(negedge clk);
            out_ready = !(cyc >= 5 && cyc < 10);
            if (sent < 8) begin
                in_valid = 1'b1;
                in_mode  = m[sent];
                in_data  = d[sent];
                in_tag   = 4'(sent);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (!in_ready) saw_stall = 1'b1;
            in_acc  = in_valid && in_ready;
            out_acc = out_valid && out_ready;
            if (out_acc) begin
                vectors++;
                if (out_data !== e[rcvd] || out_tag !== 4'(rcvd)) begin
                    miscompares++;
                    $display("FAIL bp_beat[%0d] got d=%h t=%h expected d=%h t=%h",
                             rcvd, out_data, out_tag, e[rcvd], 4'(rcvd));
                end
                rcvd++;
            end
            if (in_acc) sent++;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        vectors++;
        if (rcvd !== 8) begin
            miscompares++;
            $display("FAIL bp_count got %0d beats expected 8", rcvd);
        end
        vectors++;
        if (saw_stall !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_in_ready_drop got %b expected 1", saw_stall);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_no_duplicate cycle %0d got out_valid=%b expected 0", k, out_valid);
            end
        end
    endtask

    task automatic test_reset_mid_stream();
        logic [7:0] got;
        logic [3:0] gt;
        int         lat;
        @(negedge clk);
        in_valid = 1'b1; in_mode = 2'd0; in_data = 8'h20; in_tag = 4'h5;
        @(negedge clk);
        in_mode = 2'd1; in_data = 8'h40; in_tag = 4'h6;
        @(negedge clk);
        in_mode = 2'd2; in_data = 8'h28; in_tag = 4'h7;
        @(negedge clk);
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'h18 || out_tag !== 4'h5) begin
            miscompares++;
            $display("FAIL rst_pre got v=%b d=%h t=%h expected v=1 d=18 t=5", out_valid, out_data, out_tag);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_tag !== 4'h0) begin
            miscompares++;
            $display("FAIL rst_async got v=%b d=%h t=%h expected v=0 d=00 t=0", out_valid, out_data, out_tag);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL rst_stale cycle %0d got out_valid=%b expected 0", k, out_valid);
            end
        end
        run_beat(2'd0, 8'h21, 4'h9, got, gt, lat);
        vectors++;
        if (got !== 8'h18 || gt !== 4'h9 || lat !== 3) begin
            miscompares++;
            $display("FAIL rst_first_beat got d=%h t=%h lat=%0d expected d=18 t=9 lat=3", got, gt, lat);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_tanh();
        test_tanh_sat();
        test_sigmoid();
        test_relu_bypass();
        test_back_pressure();
        test_reset_mid_stream();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
